// File: rtl/async_fifo_reader.sv
// Read-side consumer for the async FIFO: issues reads, buffers returned data in a
// 3-entry skid ring and presents it as a valid/ready stream. Optional counters: ASYNC_FIFO_RD_STATS_EN.
module async_fifo_reader #(
    parameter int data_width = 8
) (
    input  logic                  rclk,
    input  logic                  rrstn,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           beat_count,
    output logic [15:0]           stall_count
);

    logic [data_width-1:0] mem_q [3];
    logic [data_width-1:0] mem_d [3];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [data_width-1:0] data_q, data_d;
    logic                  capture, pop;

    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign capture = inflight_q;
    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = data_q;

    // Only registered state plus fifo_empty feed the read enable; reset forces it low at once.
    assign fifo_ren = rrstn & ~fifo_empty &
                      (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (capture) begin
            mem_d[tail_q] = fifo_rdata;
            tail_d        = idx_inc(tail_q);
        end
        if (pop) head_d = idx_inc(head_q);
        case ({capture, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Output register tracks the next head entry and holds its last value when drained.
        data_d = (occ_d != 2'd0) ? mem_d[head_d] : data_q;
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            data_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_ren;
            data_q     <= data_d;
        end
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [15:0] beat_q, beat_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        beat_d  = pop ? beat_q + 16'd1 : beat_q;
        stall_d = stall_q;
        if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            beat_q  <= 16'd0;
            stall_q <= 16'd0;
        end else begin
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign beat_count  = beat_q;
    assign stall_count = stall_q;
`else
    assign beat_count  = 16'd0;
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
// Scoreboard bench for async_fifo_reader: behavioural FIFO read port, directed
// stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_async_fifo_reader;

    logic        rclk;
    logic        rrstn;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_ren;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [15:0] beat_count;
    logic [15:0] stall_count;

    async_fifo_reader #(.data_width(8)) dut (
        .rclk        (rclk),
        .rrstn       (rrstn),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .beat_count  (beat_count),
        .stall_count (stall_count)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // FIFO read-port model: registered data, pointer shares rrstn.
    logic [7:0] fmem [256];
    int         fwr;
    int         frd;
    logic       force_empty;
    logic [7:0] exp_q [$];
    int         n_chk;
    int         n_fail;

    assign fifo_empty = force_empty | (fwr == frd);

    always @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            frd        <= 0;
            fifo_rdata <= 8'h00;
        end else if (fifo_ren && fwr != frd) begin
            fifo_rdata <= fmem[frd[7:0]];
            frd        <= frd + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[fwr[7:0]] = d;
        fwr++;
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 300) begin
            @(negedge rclk);
            #1;
            k++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !m_valid)}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren"},   {31'd0, fifo_ren}, 32'd0);
        chk({tag, "_valid"}, {31'd0, m_valid},  32'd0);
        chk({tag, "_data"},  {24'd0, m_data},   32'd0);
        chk({tag, "_beat"},  {16'd0, beat_count},  32'd0);
        chk({tag, "_stall"}, {16'd0, stall_count}, 32'd0);
    endtask

    // Monitor: underflow guard and in-order beat comparison.
    always @(negedge rclk) begin
        if (rrstn) begin
            if (fifo_ren) chk("no_read_when_empty", {31'd0, fifo_empty}, 32'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("beat_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int k;
        logic [7:0] bursty [12] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56,
                                    8'h67, 8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC};
        n_chk       = 0;
        n_fail      = 0;
        fwr         = 0;
        force_empty = 1'b0;
        m_ready     = 1'b0;
        rrstn       = 1'b0;
        #12;
        chk_reset_outputs("por");
        rrstn = 1'b1;

        // Streaming: 2-cycle first-beat latency then 4 consecutive beats.
        @(posedge rclk); #1;
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        @(negedge rclk);
        chk("c0_ren",   {31'd0, fifo_ren}, 32'd1);
        chk("c0_valid", {31'd0, m_valid},  32'd0);
        @(negedge rclk);
        chk("c1_valid", {31'd0, m_valid},  32'd0);
        @(negedge rclk);
        chk("c2_valid", {31'd0, m_valid},  32'd1);
        chk("c2_data",  {24'd0, m_data},   32'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            chk("stream_consec", {31'd0, m_valid}, 32'd1);
        end
        @(negedge rclk);
        chk("stream_end_valid", {31'd0, m_valid}, 32'd0);
        wait_drain("stream_drain");

        // Backpressure: only 3 reads outstanding/buffered, head held.
        @(posedge rclk); #1;
        m_ready = 1'b0;
        r0 = frd;
        for (int i = 0; i < 8; i++) push(8'h11 * (i + 1));
        repeat (8) @(negedge rclk);
        chk("bp_reads",  frd - r0,            32'd3);
        chk("bp_ren",    {31'd0, fifo_ren},   32'd0);
        chk("bp_valid",  {31'd0, m_valid},    32'd1);
        chk("bp_data",   {24'd0, m_data},     32'h11);
        @(posedge rclk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            chk("bp_no_gap", {31'd0, m_valid}, 32'd1);
        end
        wait_drain("bp_drain");

        // Bursty: empty flag toggles every cycle, random ready.
        @(posedge rclk); #1;
        for (int i = 0; i < 12; i++) push(bursty[i]);
        for (int i = 0; i < 80; i++) begin
            force_empty = ~force_empty;
            m_ready     = 1'($urandom_range(0, 1));
            @(posedge rclk); #1;
        end
        force_empty = 1'b0;
        m_ready     = 1'b1;
        wait_drain("bursty_drain");

        // Reset mid-stream with two buffered and one in flight.
        @(posedge rclk); #1;
        m_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
        repeat (3) @(posedge rclk);
        @(negedge rclk); #2;
        rrstn = 1'b0;
        fwr   = 0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midrst");
        @(negedge rclk); #2;
        rrstn = 1'b1;
        @(posedge rclk); #1;
        m_ready = 1'b1;
        push(8'hA5); push(8'h5A);
        wait_drain("midrst_drain");

        // Stats: 10 beats with exactly 4 stall edges.
        @(negedge rclk); #2;
        rrstn = 1'b0;
        fwr   = 0;
        #1;
        rrstn = 1'b1;
        @(posedge rclk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i));
        k = 0;
        while (!m_valid && k < 50) begin
            @(negedge rclk);
            k++;
        end
        chk("stats_first_valid", {31'd0, m_valid}, 32'd1);
        repeat (4) @(posedge rclk);
        #1;
        m_ready = 1'b1;
        wait_drain("stats_drain");
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("beat_count",  {16'd0, beat_count},  32'd10);
        chk("stall_count", {16'd0, stall_count}, 32'd4);
`else
        chk("beat_count",  {16'd0, beat_count},  32'd0);
        chk("stall_count", {16'd0, stall_count}, 32'd0);
`endif

        repeat (2) @(posedge rclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_reader.md
# async_fifo_reader

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It drives the FIFO's read enable and captures the FIFO's registered read data. It turns that into a valid/ready stream toward downstream logic. It never issues a read while the FIFO reports empty, so FIFO underflow cannot occur, and it sustains one beat per clock when data is available and downstream is ready.

## Interface
Parameters:
- `data_width`, default 8: width of FIFO data and stream data.

Ports:
- `rclk`  in  1: read-domain clock; single clock for the whole block.
- `rrstn`  in  1: asynchronous, active-low reset.
- `fifo_empty`  in  1: FIFO empty flag (read domain).
- `fifo_rdata`  in  `data_width`: FIFO read data; valid the cycle after a read is accepted, held until the next accepted read.
- `fifo_ren`  out  1: FIFO read enable.
- `m_valid`  out  1: stream data valid.
- `m_data`  out  `data_width`: stream data.
- `m_ready`  in  1: downstream accepts the beat when `m_valid & m_ready`.
- `beat_count`  out  16: beats delivered (see Configuration).
- `stall_count`  out  16: stall cycles (see Configuration).

## Operation
- **Buffer:** 3-entry circular buffer with head index, tail index and occupancy `occ` (0..3). Indices wrap 2→0.
- **In-flight flag:** `inflight` register, loaded with `fifo_ren` every cycle.
- **Read issue:** `fifo_ren = ~fifo_empty & (occ + inflight < 3)`.
  - Depends only on registered state and `fifo_empty`; there is no combinational path from `m_ready`.
- **Capture:** on a clock edge with `inflight=1`, `fifo_rdata` is written at the tail and the tail advances.
- **Pop:** on a clock edge with `m_valid & m_ready`, the head advances.
- **Occupancy update:**
  - Capture and pop on the same edge: `occ` unchanged, both indices advance.
  - Capture only: `occ+1`.
  - Pop only: `occ-1`.
- **Stream outputs:**
  - `m_valid = (occ != 0)`.
  - `m_data` = entry at head, registered storage only. It holds the last head value when `m_valid=0`.
- **Invariants:** `occ + inflight ≤ 3` always; no capture into a full buffer; no read while `fifo_empty=1`.
- **Ordering:** beats leave in FIFO order, with no loss or duplication.
- **Reset (asynchronous):**
  - `fifo_ren=0`, `inflight=0`, `occ=0`, head=tail=0, all entries 0.
  - `m_valid=0`, `m_data=0`, `beat_count=0`, `stall_count=0`.
- **Reset mid-operation:** buffered and in-flight data are discarded. The FIFO read pointer shares `rrstn`, so both sides restart empty and consistent.

## Timing
- **First-beat latency:**
  - Cycle c0: `fifo_empty` low and buffer empty, so `fifo_ren=1`.
  - Edge e1: the FIFO updates `fifo_rdata`.
  - Edge e2: the block captures the data.
  - Cycle c2: `m_valid=1`.
  - Total: 2 cycles from the first non-empty cycle to `m_valid`.
- **Throughput:** steady state is `occ=1`, `inflight=1`, with a read issued every cycle, giving 1 beat/cycle.
- **Backpressure:** with `m_ready=0`, at most 3 reads are outstanding or buffered. `fifo_ren` then stays low until a pop frees space. The first new read after a pop is issued in the cycle following that pop edge.
- **`fifo_empty` rising while a read is in flight:** the in-flight data is still captured, and no further reads are issued.
- **`m_valid`/`m_data` stability:** both stay stable while `m_valid & ~m_ready`.

## Configuration
- Macro: `ASYNC_FIFO_RD_STATS_EN`.
- **Defined:**
  - `beat_count` increments on every pop edge and wraps at 2^16.
  - `stall_count` increments on every edge with `m_valid & ~m_ready` and saturates at 16'hFFFF.
  - Both counters reset to 0.
- **Undefined:** `beat_count` and `stall_count` are tied to constant 0 and no counter flops are generated; ports remain present.

## Test plan
- **Reset:** assert `rrstn=0` mid-clock → `fifo_ren=0`, `m_valid=0`, `m_data=0`, counts 0, all immediately and asynchronously.
- **Streaming:** FIFO preloaded with 0x11, 0x22, 0x33, 0x44; `m_ready=1` → first `m_valid` 2 cycles after `fifo_empty` is first low. Beats 0x11, 0x22, 0x33, 0x44 appear on 4 consecutive cycles, then `m_valid=0`; no FIFO underflow.
- **Backpressure:** FIFO holds 8 entries, `m_ready=0` → exactly 3 reads accepted, then `fifo_ren=0` while `m_data` holds 0x11. Raise `m_ready` → all 8 values delivered in order with no gaps after the pipeline refills.
- **Bursty input:** `fifo_empty` toggles every cycle with random `m_ready` → `fifo_ren` is never high while `fifo_empty=1`, and the output sequence equals the write sequence.
- **Reset mid-stream:** reset with `occ=2` and `inflight=1` → outputs clear at once. After release, new FIFO writes 0xA5, 0x5A are delivered first and in order.
- **Stats:** with the macro defined, deliver 10 beats including 4 stall cycles → `beat_count=10`, `stall_count=4`. With the macro undefined, both read 0 throughout.
